fifo_read_ctrl: RTL and testbench

Read-side controller for the async FIFO, clocked entirely in the read domain. It synchronises the write-domain Gray pointer and maintains the binary and Gray read pointers. It generates empty, almost-empty and fill-level status, and drives the memory read address. A first-word-fall-through output register with a valid/ready handshake presents data to the consumer.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_sync2.sv | 31 +++
 rtl/fifo_read_ctrl.sv | 103 ++++++++++
 tb/tb_fifo_read_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: helpers shared by the read and write sides of the async FIFO.
//   fifo_depth : number of words for a given address width
//   bin2gray   : binary to Gray conversion (32-bit, callers truncate)
//   gray2bin   : Gray to binary conversion (32-bit, callers zero-extend)
package fifo_pkg;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper Gray bits decode to zero, so a narrow pointer can be
  // passed through this full-width version and truncated afterwards.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync2.sv
// fifo_sync2: two-flop synchroniser for a Gray-coded pointer crossing into
// the local clock domain. Used on both sides of the async FIFO.
//   clk   : destination-domain clock
//   rst_n : asynchronous active-low reset
//   d     : source-domain value (unsynchronised)
//   q     : value after two destination-domain flops
module fifo_sync2 #(
  parameter int unsigned width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] wq1_q;
  logic [width-1:0] wq2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wq1_q <= '0;
      wq2_q <= '0;
    end else begin
      wq1_q <= d;
      wq2_q <= wq1_q;
    end
  end

  assign q = wq2_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side controller of the async FIFO, read domain only.
// Synchronises the write Gray pointer, keeps binary/Gray read pointers,
// produces empty / almost-empty / level status and a first-word-fall-through
// output register with a valid/ready handshake.
//   read_clk, read_rst_n : clock, async active-low reset
//   write_ptr_gray       : write pointer (Gray), unsynchronised
//   read_data            : memory data at read_address (combinational)
//   out_ready            : consumer accepts out_data
//   read_address         : memory read address
//   read_ptr_gray        : registered Gray read pointer to the write side
//   read_empty           : no unread word in memory
//   read_almost_empty    : read_level <= almost_empty_level
//   read_level           : unread words in memory (conservative)
//   out_data, out_valid  : output register and its valid flag
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned data_size          = 8,
  parameter int unsigned address_size       = 3,
  parameter int unsigned almost_empty_level = 1
) (
  input  logic                    read_clk,
  input  logic                    read_rst_n,
  input  logic [address_size:0]   write_ptr_gray,
  input  logic [data_size-1:0]    read_data,
  input  logic                    out_ready,
  output logic [address_size-1:0] read_address,
  output logic [address_size:0]   read_ptr_gray,
  output logic                    read_empty,
  output logic                    read_almost_empty,
  output logic [address_size:0]   read_level,
  output logic [data_size-1:0]    out_data,
  output logic                    out_valid
);

  localparam int unsigned depth = fifo_depth(address_size);
  localparam int unsigned ptr_w = $clog2(depth) + 1;

  logic [ptr_w-1:0]     wq2;
  logic [ptr_w-1:0]     rbin_q, rbin_d;
  logic [ptr_w-1:0]     rgray_q, rgray_d;
  logic [ptr_w-1:0]     level_q, level_d;
  logic                 empty_q, empty_d;
  logic                 almost_q, almost_d;
  logic [data_size-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 pop;

  fifo_sync2 #(.width(ptr_w)) u_sync_wptr (
    .clk   (read_clk),
    .rst_n (read_rst_n),
    .d     (write_ptr_gray),
    .q     (wq2)
  );

  always_comb begin
    pop         = !empty_q && (!out_valid_q || out_ready);
    rbin_d      = rbin_q + ptr_w'(pop);
    rgray_d     = ptr_w'(bin2gray(32'(rbin_d)));
    empty_d     = (rgray_d == wq2);
    // Modulo subtraction against the lagging synchronised pointer: the level
    // may under-report during a write race but never over-reports.
    level_d     = ptr_w'(gray2bin(32'(wq2))) - rbin_d;
    almost_d    = (32'(level_d) <= almost_empty_level);
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (pop) begin
      out_data_d  = read_data;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      rbin_q      <= '0;
      rgray_q     <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      almost_q    <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rgray_q     <= rgray_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      almost_q    <= almost_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign read_address      = rbin_q[address_size-1:0];
  assign read_ptr_gray     = rgray_q;
  assign read_empty        = empty_q;
  assign read_almost_empty = almost_q;
  assign read_level        = level_q;
  assign out_data          = out_data_q;
  assign out_valid         = out_valid_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;

  logic       read_clk;
  logic       read_rst_n;
  logic [3:0] write_ptr_gray;
  logic [7:0] read_data;
  logic       out_ready;
  logic [2:0] read_address;
  logic [3:0] read_ptr_gray;
  logic       read_empty;
  logic       read_almost_empty;
  logic [3:0] read_level;
  logic [7:0] out_data;
  logic       out_valid;

  fifo_read_ctrl #(.data_size(8), .address_size(3), .almost_empty_level(1)) dut (
    .read_clk          (read_clk),
    .read_rst_n        (read_rst_n),
    .write_ptr_gray    (write_ptr_gray),
    .read_data         (read_data),
    .out_ready         (out_ready),
    .read_address      (read_address),
    .read_ptr_gray     (read_ptr_gray),
    .read_empty        (read_empty),
    .read_almost_empty (read_almost_empty),
    .read_level        (read_level),
    .out_data          (out_data),
    .out_valid         (out_valid)
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  // Memory model: written by the bench's writer, read combinationally.
  logic [7:0] mem [8];
  assign read_data = mem[read_address];

  int n_checks = 0;
  int n_fail   = 0;
  int wcnt     = 0;   // words written so far
  int delivered = 0;  // beats accepted by the consumer
  logic [7:0] exp_q[$];

  typedef struct {
    logic [3:0] wpg;
    logic       rdy;
    logic       e_empty;
    logic       e_valid;
    logic [7:0] e_data;
    logic [2:0] e_addr;
    logic [3:0] e_rpg;
    logic [3:0] e_level;
    logic       e_almost;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] gray_of(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic write_word(input logic [7:0] d);
    mem[wcnt % 8] = d;
    exp_q.push_back(d);
    wcnt++;
    write_ptr_gray = gray_of(wcnt);
  endtask

  task automatic reset_dut();
    read_rst_n = 1'b0;
    wcnt = 0;
    delivered = 0;
    exp_q.delete();
    write_ptr_gray = 4'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge read_clk);
    #1;
    read_rst_n = 1'b1;
  endtask

  // One clock with out_ready=rdy; scores beats and checks output stability.
  task automatic step(input logic rdy);
    logic       pre_valid;
    logic [7:0] pre_data;
    logic [7:0] e;
    out_ready = rdy;
    pre_valid = out_valid;
    pre_data  = out_data;
    @(posedge read_clk);
    #1;
    if (pre_valid && rdy) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 32'(pre_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(pre_data), 32'(e));
      end
      delivered++;
    end
    if (pre_valid && !rdy) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(pre_data));
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      step(1'b1);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_invariants();
    int unread;
    unread = wcnt - delivered - int'(out_valid);
    chk("empty_vs_level", 32'(read_empty), 32'(read_level == 4'd0));
    chk("almost_vs_level", 32'(read_almost_empty), 32'(read_level <= 4'd1));
    chk("level_conservative", 32'(int'(read_level) <= unread), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lvl_wait;
    bit seen_full_wrap;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    read_rst_n = 1'b1;
    write_ptr_gray = 4'd0;
    out_ready = 1'b0;
    #3;

    // Reset values
    reset_dut();
    chk("rst_empty", 32'(read_empty), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(read_address), 32'd0);
    chk("rst_rpg", 32'(read_ptr_gray), 32'd0);
    chk("rst_level", 32'(read_level), 32'd0);
    chk("rst_almost", 32'(read_almost_empty), 32'd1);

    // Single word latency and hold, table driven
    mem[0] = 8'hA5;
    vecs[0] = '{4'b0001, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 4'd0, 1'b1};
    vecs[1] = '{4'b0001, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 4'd0, 1'b1};
    vecs[2] = '{4'b0001, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 4'd0, 4'd1, 1'b1};
    vecs[3] = '{4'b0001, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1, 4'd1, 4'd0, 1'b1};
    vecs[4] = '{4'b0001, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1, 4'd1, 4'd0, 1'b1};
    vecs[5] = '{4'b0001, 1'b1, 1'b1, 1'b0, 8'hA5, 3'd1, 4'd1, 4'd0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      write_ptr_gray = vecs[i].wpg;
      out_ready = vecs[i].rdy;
      @(posedge read_clk);
      #1;
      chk($sformatf("vec%0d_empty", i), 32'(read_empty), 32'(vecs[i].e_empty));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d_addr", i), 32'(read_address), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d_rpg", i), 32'(read_ptr_gray), 32'(vecs[i].e_rpg));
      chk($sformatf("vec%0d_level", i), 32'(read_level), 32'(vecs[i].e_level));
      chk($sformatf("vec%0d_almost", i), 32'(read_almost_empty), 32'(vecs[i].e_almost));
    end

    // Full-depth burst with wrap
    reset_dut();
    for (int i = 0; i < 8; i++) write_word(8'h10 + 8'(i));
    chk("burst_wpg", 32'(write_ptr_gray), 32'b1100);
    seen_full_wrap = 0;
    for (int n = 0; n < 30 && delivered < 8; n++) begin
      step(1'b1);
      if (!seen_full_wrap && read_ptr_gray == 4'b1100) begin
        seen_full_wrap = 1;
        chk("burst_last_pop_empty", 32'(read_empty), 32'd1);
      end
    end
    chk("burst_count", 32'(delivered), 32'd8);
    chk("burst_rpg", 32'(read_ptr_gray), 32'b1100);
    chk("burst_addr", 32'(read_address), 32'd0);
    chk("burst_empty", 32'(read_empty), 32'd1);

    // Backpressure pattern 1,0,0,1
    for (int i = 0; i < 4; i++) write_word(8'h20 + 8'(i));
    for (int n = 0; n < 40 && delivered < 12; n++) begin
      step((n % 4 == 0) || (n % 4 == 3));
    end
    chk("bp_count", 32'(delivered), 32'd12);
    chk("bp_leftover", 32'(exp_q.size()), 32'd0);

    // Level countdown and almost-empty
    reset_dut();
    for (int i = 0; i < 3; i++) write_word(8'h30 + 8'(i));
    lvl_wait = 0;
    step(1'b1);
    while (read_level == 4'd0 && lvl_wait < 10) begin
      step(1'b1);
      lvl_wait++;
    end
    chk("lvl3", 32'(read_level), 32'd3);
    chk("lvl3_almost", 32'(read_almost_empty), 32'd0);
    step(1'b1);
    chk("lvl2", 32'(read_level), 32'd2);
    chk("lvl2_almost", 32'(read_almost_empty), 32'd0);
    step(1'b1);
    chk("lvl1", 32'(read_level), 32'd1);
    chk("lvl1_almost", 32'(read_almost_empty), 32'd1);
    step(1'b1);
    chk("lvl0", 32'(read_level), 32'd0);
    chk("lvl0_almost", 32'(read_almost_empty), 32'd1);
    chk("lvl0_empty", 32'(read_empty), 32'd1);
    drain(20);

    // Asynchronous reset mid-operation
    reset_dut();
    for (int i = 0; i < 6; i++) write_word(8'h40 + 8'(i));
    repeat (4) step(1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_level", 32'(read_level), 32'd5);
    #2;
    read_rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_empty", 32'(read_empty), 32'd1);
    chk("arst_level", 32'(read_level), 32'd0);
    chk("arst_almost", 32'(read_almost_empty), 32'd1);
    chk("arst_addr", 32'(read_address), 32'd0);
    chk("arst_rpg", 32'(read_ptr_gray), 32'd0);
    reset_dut();

    // Randomised traffic against the count/queue model
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 2) != 0 && (wcnt - delivered) < 8)
        write_word(8'($urandom));
      step($urandom_range(0, 3) != 0);
      check_invariants();
    end
    drain(60);
    chk("rand_all_delivered", 32'(delivered), 32'(wcnt));
    repeat (4) step(1'b1);
    chk("rand_final_empty", 32'(read_empty), 32'd1);
    chk("rand_final_level", 32'(read_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
